// File: rtl/log_ram_pkg.sv
// Shared state and mode encodings for the log-to-RAM capture controller.
package log_ram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_PRE  = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic MODE_FILL = 1'b0;
    localparam logic MODE_CIRC = 1'b1;

endpackage

// File: rtl/log_ram_ctrl_rise_edge_det.sv
// Purpose: one-flop rising-edge detector for the micro run request.
// Latency: o_rise is combinational in the cycle i_din first reads high.
// Backpressure: none.
module rise_edge_det (
    input  logic clock,
    input  logic i_reset,
    input  logic i_din,
    output logic o_rise
);

    logic din_q;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) din_q <= 1'b0;
        else         din_q <= i_din;
    end

    assign o_rise = i_din & ~din_q;

endmodule

// File: rtl/log_ram_ctrl.sv
// Purpose: log RAM capture controller (single fill, optional circular pre/post trigger via LOG_RAM_CIRCULAR_EN).
// Latency: run edge at N -> busy/first write at N+1; last write at M -> full at M+1; o_wr_en combinational.
// Backpressure: none; writes are gated only by i_sample_valid, i_stop aborts to IDLE.
module log_ram_ctrl
    import log_ram_pkg::*;
#(
    parameter int NB_ADDR = 3
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_run,
    input  logic               i_stop,
    input  logic               i_sample_valid,
    input  logic               i_mode,
    input  logic               i_trigger,
    input  logic [NB_ADDR-1:0] i_post_count,
    output logic               o_wr_en,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic               o_full_mem,
    output logic               o_busy,
    output logic [NB_ADDR-1:0] o_trig_addr,
    output logic               o_wrapped
);

    localparam int RAM_DEPTH = 2**NB_ADDR;
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(RAM_DEPTH - 1);

    state_t             state, state_nxt;
    logic [NB_ADDR-1:0] addr, addr_nxt;
    logic [NB_ADDR-1:0] trig, trig_nxt;
    logic [NB_ADDR-1:0] post_cnt, post_nxt;
    logic               full, full_nxt;
    logic               wrapped, wrapped_nxt;
    logic               run_rise;
    logic               capturing;

    rise_edge_det u_run_edge (
        .clock   (clock),
        .i_reset (i_reset),
        .i_din   (i_run),
        .o_rise  (run_rise)
    );

    assign capturing = (state == ST_FILL) || (state == ST_PRE) || (state == ST_POST);

`ifndef LOG_RAM_CIRCULAR_EN
    logic unused_circ_inputs;
    assign unused_circ_inputs = ^{i_mode, i_trigger, i_post_count};
`endif

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr;
        trig_nxt    = trig;
        post_nxt    = post_cnt;
        full_nxt    = full;
        wrapped_nxt = wrapped;
        case (state)
            ST_IDLE, ST_DONE: begin
                // an abort in the same cycle suppresses the run edge
                if (run_rise && !i_stop) begin
                    addr_nxt    = '0;
                    trig_nxt    = '0;
                    full_nxt    = 1'b0;
                    wrapped_nxt = 1'b0;
                    state_nxt   = ST_FILL;
`ifdef LOG_RAM_CIRCULAR_EN
                    if (i_mode == MODE_CIRC) state_nxt = ST_PRE;
`endif
                end
            end
            ST_FILL: begin
                if (i_stop) begin
                    state_nxt = ST_IDLE;
                end else if (i_sample_valid) begin
                    if (addr == LAST_ADDR) begin
                        state_nxt = ST_DONE;
                        full_nxt  = 1'b1;
                    end else begin
                        addr_nxt = addr + 1'b1;
                    end
                end
            end
`ifdef LOG_RAM_CIRCULAR_EN
            ST_PRE: begin
                if (i_stop) begin
                    state_nxt = ST_IDLE;
                end else begin
                    if (i_sample_valid) begin
                        addr_nxt = addr + 1'b1;
                        if (addr == LAST_ADDR) wrapped_nxt = 1'b1;
                    end
                    if (i_trigger) begin
                        trig_nxt = addr;
                        post_nxt = i_post_count;
                        if (i_post_count == '0) begin
                            state_nxt = ST_DONE;
                            full_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_POST;
                        end
                    end
                end
            end
            ST_POST: begin
                if (i_stop) begin
                    state_nxt = ST_IDLE;
                end else if (i_sample_valid) begin
                    addr_nxt = addr + 1'b1;
                    post_nxt = post_cnt - 1'b1;
                    if (post_cnt == NB_ADDR'(1)) begin
                        state_nxt = ST_DONE;
                        full_nxt  = 1'b1;
                    end
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            addr     <= '0;
            trig     <= '0;
            post_cnt <= '0;
            full     <= 1'b0;
            wrapped  <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            trig     <= trig_nxt;
            post_cnt <= post_nxt;
            full     <= full_nxt;
            wrapped  <= wrapped_nxt;
        end
    end

    assign o_wr_en     = capturing & i_sample_valid;
    assign o_wr_addr   = addr;
    assign o_full_mem  = full;
    assign o_busy      = capturing;
    assign o_trig_addr = trig;
    assign o_wrapped   = wrapped;

endmodule

// File: doc/log_ram_ctrl.md
# log_ram_ctrl

Parametrised capture controller for the log-to-RAM path: detects a run request from the micro, generates RAM write enable and address for each valid sample, and flags memory full. It extends the single-shot fill controller with a configurable depth, sample-valid gating, an abort input, and an optional circular pre/post-trigger capture mode. It sits between the micro register interface and the log RAM write port.

## Interface
- NB_ADDR, 3, address width; RAM depth is 2**NB_ADDR
- RAM_DEPTH, 2**NB_ADDR, derived localparam, not overridable
- clock  in  1  system clock, all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_run  in  1  capture request from micro; rising-edge detected internally
- i_stop  in  1  synchronous abort, level-sensitive
- i_sample_valid  in  1  sample present this cycle
- i_mode  in  1  0 = single fill, 1 = circular (only with LOG_RAM_CIRCULAR_EN)
- i_trigger  in  1  trigger event, circular mode only
- i_post_count  in  NB_ADDR  samples to capture after the trigger sample
- o_wr_en  out  1  RAM write enable
- o_wr_addr  out  NB_ADDR  RAM write address
- o_full_mem  out  1  capture complete, sticky until next run edge
- o_busy  out  1  capture in progress
- o_trig_addr  out  NB_ADDR  address of trigger sample
- o_wrapped  out  1  circular buffer wrapped at least once

## Operation
- States: IDLE, FILL, PRE, POST, DONE.
- IDLE/DONE + run rising edge -> clear address, o_full_mem, o_wrapped, o_trig_addr; go FILL (i_mode=0) or PRE (i_mode=1).
- Run edge while FILL/PRE/POST: ignored.
- o_wr_en = i_sample_valid when state is FILL, PRE or POST; else 0. Address increments by 1 after each write, mod RAM_DEPTH.
- FILL: write at address RAM_DEPTH-1 -> DONE; address stays at RAM_DEPTH-1; o_full_mem=1.
- PRE: writes wrap; roll from RAM_DEPTH-1 to 0 sets o_wrapped (sticky). i_trigger=1 -> o_trig_addr = current o_wr_addr; load post counter with i_post_count; go POST (or DONE if i_post_count=0). The trigger cycle's write, if valid, is the trigger sample.
- POST: each write decrements post counter; write with counter=1 -> DONE, o_full_mem=1.
- i_trigger outside PRE: ignored.
- i_stop in FILL/PRE/POST -> IDLE; o_full_mem stays 0; address, o_wrapped and o_trig_addr hold. i_stop and run edge in the same cycle: stop wins.
- o_busy = 1 in FILL, PRE, POST.

## Timing
- Reset: state IDLE, all outputs 0, edge-detector history 0.
- Run edge sampled at cycle N -> o_busy=1 and first possible write at N+1.
- o_wr_en is combinational from registered state and i_sample_valid; all other outputs are registered.
- Last write at cycle M -> o_full_mem=1, o_busy=0 at M+1.
- Trigger at cycle T -> o_trig_addr valid from T+1.
- Reset asserted mid-capture -> immediate return to reset values; no write completes.

## Configuration
- LOG_RAM_CIRCULAR_EN defined: PRE/POST states, i_trigger, i_post_count, o_trig_addr and o_wrapped are functional.
- Not defined: i_mode is ignored (always single fill); o_trig_addr and o_wrapped are tied to 0; PRE/POST logic is not compiled; ports remain present.

## Structure
- Package log_ram_pkg: state encoding constants and mode constants (MODE_FILL, MODE_CIRC).
- Sub-module rise_edge_det: one-flop rising-edge detector for i_run, using clock and i_reset.

## Test plan
- NB_ADDR=3, run pulse, i_sample_valid held 1 -> addresses 0..7 written on consecutive cycles; o_full_mem=1 the cycle after the address-7 write; no write afterwards.
- Fill with i_sample_valid toggling 1/0 -> exactly 8 writes; address advances only on valid cycles; o_full_mem rises after the 8th write.
- Stop asserted after 3 writes -> IDLE; o_wr_addr=3; o_full_mem=0; a new run edge restarts at address 0.
- Circular mode, i_post_count=2, trigger at address 5 after 10 writes -> o_wrapped=1, o_trig_addr=5, last write at address 7, then DONE.
- Run edge and stop in the same cycle from IDLE -> stays IDLE; run held high for many cycles -> exactly one capture; reset mid-FILL -> all outputs 0 immediately.
- Macro undefined, i_mode=1 -> single-fill behaviour; o_trig_addr=0 and o_wrapped=0 throughout.
